ame_pivot_sched: RTL and testbench

Initiator side of the AME pivot-compare interface. It sequences partial-pivot selection for the 6x6 affine-parameter linear system. For each column k = 0..5 it:
- fetches the column from the matrix buffer,
- drives the pivot comparator with the data and the mask of already-used rows,
- publishes the chosen pivot row to the elimination engine,
- records the row permutation.

It sits between the matrix buffer, the comparator instance and the elimination engine in the AME solver.

---
 rtl/ame_pkg.sv | 21 ++
 rtl/ame_pivot_sched.sv | 167 ++++++++++++++++
 tb/tb_ame_pivot_sched.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ame_pkg.sv
// Shared types and constants for the AME pivot-selection path.
// The 6x6 system size and the "unresolved" permutation code live here.
package ame_pkg;

    localparam int AME_ROWS     = 6;
    localparam int AME_IDX_BITS = 3;

    localparam logic [AME_IDX_BITS-1:0] PERM_INVALID = 3'h7;

    typedef logic [AME_IDX_BITS-1:0] ame_idx_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        CMP  = 3'd3,
        PIV  = 3'd4,
        DONE = 3'd5
    } pivot_state_t;

endpackage

// File: rtl/ame_pivot_sched.sv
// Partial-pivot scheduler: walks columns 0..5, asks the shared comparator for
// the best unused row, publishes it to the elimination engine, records perm.
//
// state | meaning
// IDLE  | waiting for start_i
// RD    | column read strobe for column k
// WAIT  | column data arrives, latched toward the comparator
// CMP   | comparator request held until comp_done_i
// PIV   | pivot record offered until piv_ready_i
// DONE  | one-cycle completion pulse
module ame_pivot_sched
    import ame_pkg::*;
#(
    parameter int DATA_BITS = 64,
    parameter int IDX_BITS  = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          singular_o,
    output logic                          col_rd_en_o,
    output logic [IDX_BITS-1:0]           col_rd_addr_o,
    input  logic [AME_ROWS*DATA_BITS-1:0] col_rd_data_i,
    output logic                          comp_init_o,
    input  logic                          comp_done_i,
    output logic [AME_ROWS*DATA_BITS-1:0] comp_data_o,
    output logic [AME_ROWS-1:0]           comp_data_mask_o,
    input  logic [DATA_BITS-1:0]          comp_data_i,
    input  logic [IDX_BITS-1:0]           comp_data_index_i,
    output logic                          piv_valid_o,
    input  logic                          piv_ready_i,
    output logic [IDX_BITS-1:0]           piv_col_o,
    output logic [IDX_BITS-1:0]           piv_row_o,
    output logic [DATA_BITS-1:0]          piv_data_o,
    output logic [AME_ROWS*IDX_BITS-1:0]  perm_o
);

    localparam logic [IDX_BITS-1:0] LAST_COL  = IDX_BITS'(AME_ROWS - 1);
    localparam logic [IDX_BITS-1:0] NUM_ROWS  = IDX_BITS'(AME_ROWS);
    localparam logic [IDX_BITS-1:0] PERM_NONE = IDX_BITS'(PERM_INVALID);

    pivot_state_t                         state_q;
    pivot_state_t                         state_d;
    logic [IDX_BITS-1:0]                  k_q;
    logic [AME_ROWS-1:0]                  mask_q;
    logic [AME_ROWS*DATA_BITS-1:0]        comp_data_q;
    logic [AME_ROWS-1:0][IDX_BITS-1:0]    perm_q;
    logic                                 singular_q;
    logic [IDX_BITS-1:0]                  piv_col_q;
    logic [IDX_BITS-1:0]                  piv_row_q;
    logic [DATA_BITS-1:0]                 piv_data_q;
    logic                                 mask_hit;
    logic                                 cand_bad;

    // A returned row that is already used, out of range, or carries a zero
    // value means no usable pivot is left in this column. The most-negative
    // value is nonzero and therefore accepted.
    always_comb begin
        mask_hit = 1'b0;
        for (int r = 0; r < AME_ROWS; r++) begin
            if (comp_data_index_i == IDX_BITS'(r)) begin
                mask_hit = mask_q[r];
            end
        end
        cand_bad = mask_hit || (comp_data_index_i >= NUM_ROWS) || (comp_data_i == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_i) state_d = RD;
            RD:   state_d = WAIT;
            WAIT: state_d = CMP;
            CMP:  if (comp_done_i) state_d = cand_bad ? DONE : PIV;
            PIV:  if (piv_ready_i) state_d = (k_q == LAST_COL) ? DONE : RD;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q != IDLE);
        done_o      = (state_q == DONE);
        col_rd_en_o = (state_q == RD);
        comp_init_o = (state_q == CMP);
        piv_valid_o = (state_q == PIV);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            k_q         <= '0;
            mask_q      <= '0;
            comp_data_q <= '0;
            singular_q  <= 1'b0;
            piv_col_q   <= '0;
            piv_row_q   <= '0;
            piv_data_q  <= '0;
            for (int r = 0; r < AME_ROWS; r++) begin
                perm_q[r] <= PERM_NONE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        k_q        <= '0;
                        mask_q     <= '0;
                        singular_q <= 1'b0;
                        for (int r = 0; r < AME_ROWS; r++) begin
                            perm_q[r] <= PERM_NONE;
                        end
                    end
                end
                WAIT: begin
                    comp_data_q <= col_rd_data_i;
                end
                CMP: begin
                    if (comp_done_i) begin
                        if (cand_bad) begin
                            singular_q <= 1'b1;
                        end else begin
                            piv_col_q  <= k_q;
                            piv_row_q  <= comp_data_index_i;
                            piv_data_q <= comp_data_i;
                            for (int r = 0; r < AME_ROWS; r++) begin
                                if (k_q == IDX_BITS'(r)) begin
                                    perm_q[r] <= comp_data_index_i;
                                end
                                if (comp_data_index_i == IDX_BITS'(r)) begin
                                    mask_q[r] <= 1'b1;
                                end
                            end
                        end
                    end
                end
                PIV: begin
                    // The next column is fetched only after the handshake so the
                    // elimination engine can rewrite the buffer first.
                    if (piv_ready_i && (k_q != LAST_COL)) begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign singular_o       = singular_q;
    assign col_rd_addr_o    = k_q;
    assign comp_data_o      = comp_data_q;
    assign comp_data_mask_o = mask_q;
    assign piv_col_o        = piv_col_q;
    assign piv_row_o        = piv_row_q;
    assign piv_data_o       = piv_data_q;
    assign perm_o           = perm_q;

endmodule

// File: tb/tb_ame_pivot_sched.sv
// Directed bench for ame_pivot_sched with a behavioural column buffer and
// pivot comparator (max magnitude over unmasked rows, higher row on ties).
module tb_ame_pivot_sched;

    localparam int DB = 64;
    localparam int IB = 3;
    localparam int NR = 6;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                start_i;
    logic                busy_o, done_o, singular_o;
    logic                col_rd_en_o;
    logic [IB-1:0]       col_rd_addr_o;
    logic [NR*DB-1:0]    col_rd_data_i;
    logic                comp_init_o, comp_done_i;
    logic [NR*DB-1:0]    comp_data_o;
    logic [NR-1:0]       comp_data_mask_o;
    logic [DB-1:0]       comp_data_i;
    logic [IB-1:0]       comp_data_index_i;
    logic                piv_valid_o, piv_ready_i;
    logic [IB-1:0]       piv_col_o, piv_row_o;
    logic [DB-1:0]       piv_data_o;
    logic [NR*IB-1:0]    perm_o;

    ame_pivot_sched #(.DATA_BITS(DB), .IDX_BITS(IB)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .singular_o(singular_o),
        .col_rd_en_o(col_rd_en_o), .col_rd_addr_o(col_rd_addr_o), .col_rd_data_i(col_rd_data_i),
        .comp_init_o(comp_init_o), .comp_done_i(comp_done_i), .comp_data_o(comp_data_o),
        .comp_data_mask_o(comp_data_mask_o), .comp_data_i(comp_data_i),
        .comp_data_index_i(comp_data_index_i),
        .piv_valid_o(piv_valid_o), .piv_ready_i(piv_ready_i),
        .piv_col_o(piv_col_o), .piv_row_o(piv_row_o), .piv_data_o(piv_data_o),
        .perm_o(perm_o)
    );

    always #5 clk_i = ~clk_i;

    logic [DB-1:0] mat [NR][NR];
    int            cmp_delay;
    int            cmp_cnt = 0;
    int            cyc = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Column buffer: data valid exactly one cycle after the read strobe.
    always @(posedge clk_i) begin
        if (col_rd_en_o) begin
            for (int r = 0; r < NR; r++) begin
                col_rd_data_i[r*DB +: DB] <= mat[r][col_rd_addr_o];
            end
        end
    end

    logic [DB-1:0] cv, cm, best_mag;
    logic          found;
    always_comb begin
        comp_data_i       = '0;
        comp_data_index_i = '0;
        best_mag          = '0;
        found             = 1'b0;
        cv                = '0;
        cm                = '0;
        for (int r = 0; r < NR; r++) begin
            if (!comp_data_mask_o[r]) begin
                cv = comp_data_o[r*DB +: DB];
                cm = cv[DB-1] ? (~cv + 64'd1) : cv;
                if (!found || cm >= best_mag) begin
                    found             = 1'b1;
                    best_mag          = cm;
                    comp_data_i       = cv;
                    comp_data_index_i = IB'(r);
                end
            end
        end
    end

    assign comp_done_i = comp_init_o && (cmp_cnt == cmp_delay);
    always @(posedge clk_i) cmp_cnt <= (comp_init_o && !comp_done_i) ? cmp_cnt + 1 : 0;

    // Passive monitors, sampled mid-cycle.
    int             busy_cnt = 0, done_cnt = 0, hs_cnt = 0, rd_cnt = 0;
    int             pstab_err = 0, cstab_err = 0;
    logic [DB-1:0]  piv_log [256];
    int             rd_log  [256];
    logic           prev_pw = 1'b0, prev_cw = 1'b0;
    logic [DB+2*IB-1:0]     saved_p;
    logic [NR*DB+NR-1:0]    saved_c;

    always @(negedge clk_i) begin
        if (busy_o) busy_cnt <= busy_cnt + 1;
        if (done_o) done_cnt <= done_cnt + 1;
        if (col_rd_en_o) begin
            rd_log[rd_cnt[7:0]] <= cyc;
            rd_cnt <= rd_cnt + 1;
        end
        if (piv_valid_o && piv_ready_i) begin
            piv_log[hs_cnt[7:0]] <= piv_data_o;
            hs_cnt <= hs_cnt + 1;
        end
        if (piv_valid_o && prev_pw && ({piv_col_o, piv_row_o, piv_data_o} != saved_p))
            pstab_err <= pstab_err + 1;
        if (comp_init_o && prev_cw && ({comp_data_o, comp_data_mask_o} != saved_c))
            cstab_err <= cstab_err + 1;
        prev_pw <= piv_valid_o && !piv_ready_i;
        prev_cw <= comp_init_o && !comp_done_i;
        saved_p <= {piv_col_o, piv_row_o, piv_data_o};
        saved_c <= {comp_data_o, comp_data_mask_o};
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int t0;
    int busy_b, done_b, hs_b, rd_b, ps_b, cs_b;

    task automatic start_run();
        busy_b = busy_cnt; done_b = done_cnt; hs_b = hs_cnt;
        rd_b = rd_cnt; ps_b = pstab_err; cs_b = cstab_err;
        @(negedge clk_i);
        start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        t0 = cyc - 1;
    endtask

    task automatic wait_done(output int dc);
        while (!done_o && (cyc - t0) < 300) @(negedge clk_i);
        dc = done_o ? (cyc - t0) : -1;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk_i);
    endtask

    task automatic load_identity();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NR; c++)
                mat[r][c] = (r == c) ? 64'd1 : 64'd0;
    endtask

    localparam logic [17:0] PERM_ID   = 18'h2C688;
    localparam logic [17:0] PERM_ANTI = 18'h014E5;
    localparam logic [17:0] PERM_SING = 18'h3FFC8;
    localparam logic [17:0] PERM_RST  = 18'h3FFFF;

    int dc;
    int g;

    initial begin
        rst_i = 1'b1; start_i = 1'b0; piv_ready_i = 1'b1; cmp_delay = 0;
        load_identity();
        repeat (3) @(negedge clk_i);
        check("rst_busy",  64'(busy_o), 64'd0);
        check("rst_done",  64'(done_o), 64'd0);
        check("rst_sing",  64'(singular_o), 64'd0);
        check("rst_rd",    64'(col_rd_en_o), 64'd0);
        check("rst_init",  64'(comp_init_o), 64'd0);
        check("rst_pv",    64'(piv_valid_o), 64'd0);
        check("rst_mask",  64'(comp_data_mask_o), 64'd0);
        check("rst_cdata", 64'(comp_data_o == '0), 64'd1);
        check("rst_pfld",  64'({piv_col_o, piv_row_o, piv_data_o} == '0), 64'd1);
        check("rst_perm",  64'(perm_o), 64'(PERM_RST));
        rst_i = 1'b0;

        // identity
        start_run();
        wait_done(dc);
        check("id_done_cyc", 64'(dc), 64'd25);
        settle();
        check("id_perm", 64'(perm_o), 64'(PERM_ID));
        check("id_sing", 64'(singular_o), 64'd0);
        check("id_hs",   64'(hs_cnt - hs_b), 64'd6);
        check("id_busy", 64'(busy_cnt - busy_b), 64'd25);
        check("id_donecnt", 64'(done_cnt - done_b), 64'd1);
        for (int i = 0; i < NR; i++) check("id_pdata", piv_log[8'(hs_b + i)], 64'd1);

        // anti-diagonal, -3 pivots
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NR; c++)
                mat[r][c] = (r == NR - 1 - c) ? 64'hFFFF_FFFF_FFFF_FFFD : 64'd0;
        start_run();
        wait_done(dc);
        check("anti_done_cyc", 64'(dc), 64'd25);
        settle();
        check("anti_perm", 64'(perm_o), 64'(PERM_ANTI));
        for (int i = 0; i < NR; i++) check("anti_pdata", piv_log[8'(hs_b + i)], 64'hFFFF_FFFF_FFFF_FFFD);

        // column 2 zero in every unused row; masked row 0 holds a nonzero
        load_identity();
        mat[2][2] = 64'd0;
        mat[0][2] = 64'd9;
        start_run();
        wait_done(dc);
        check("sing_done_cyc", 64'(dc), 64'd12);
        settle();
        check("sing_flag", 64'(singular_o), 64'd1);
        check("sing_perm", 64'(perm_o), 64'(PERM_SING));
        check("sing_hs",   64'(hs_cnt - hs_b), 64'd2);
        check("sing_donecnt", 64'(done_cnt - done_b), 64'd1);

        // ready stalled 5 cycles on column 0; most-negative pivot value
        load_identity();
        mat[0][0] = 64'h8000_0000_0000_0000;
        piv_ready_i = 1'b0;
        start_run();
        g = 0;
        while (!piv_valid_o && g < 50) begin @(negedge clk_i); g++; end
        check("stall_pv_cyc", 64'(cyc - t0), 64'd4);
        repeat (5) @(negedge clk_i);
        piv_ready_i = 1'b1;
        wait_done(dc);
        check("stall_done_cyc", 64'(dc), 64'd30);
        settle();
        check("stall_rd2_cyc", 64'(rd_log[8'(rd_b + 1)] - t0), 64'd10);
        check("stall_pstable", 64'(pstab_err - ps_b), 64'd0);
        check("stall_minneg", piv_log[8'(hs_b)], 64'h8000_0000_0000_0000);
        check("stall_sing_clr", 64'(singular_o), 64'd0);
        check("stall_perm", 64'(perm_o), 64'(PERM_ID));

        // comparator answers after 3 wait cycles
        load_identity();
        cmp_delay = 3;
        start_run();
        wait_done(dc);
        check("dly_done_cyc", 64'(dc), 64'd43);
        settle();
        check("dly_perm", 64'(perm_o), 64'(PERM_ID));
        check("dly_cstable", 64'(cstab_err - cs_b), 64'd0);
        cmp_delay = 0;

        // reset during CMP of column 3, then a clean rerun
        start_run();
        g = 0;
        while (!(comp_init_o && col_rd_addr_o == 3'd3) && g < 100) begin @(negedge clk_i); g++; end
        check("mrst_reach_cmp3", 64'(cyc - t0), 64'd15);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("mrst_busy", 64'(busy_o), 64'd0);
        check("mrst_init", 64'(comp_init_o), 64'd0);
        check("mrst_pv",   64'(piv_valid_o), 64'd0);
        check("mrst_perm", 64'(perm_o), 64'(PERM_RST));
        check("mrst_mask", 64'(comp_data_mask_o), 64'd0);
        check("mrst_cdata", 64'(comp_data_o == '0), 64'd1);
        check("mrst_prow", 64'(piv_row_o), 64'd0);
        settle();
        check("mrst_nodone", 64'(done_cnt - done_b), 64'd0);
        rst_i = 1'b0;
        start_run();
        wait_done(dc);
        check("rerun_done_cyc", 64'(dc), 64'd25);
        settle();
        check("rerun_perm", 64'(perm_o), 64'(PERM_ID));
        check("rerun_sing", 64'(singular_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
